ccr_unit: RTL and testbench
===========================

# ccr_unit

Condition-code register for the 8-bit pipelined processor. Captures the Zero/Negative/Carry/Overflow flags produced by the ALU, feeds the stored carry back to the ALU for rotate-through-carry operations, and evaluates conditional branches against the stored flags. Optionally saves and restores the flags across nested interrupts on a small shadow stack. Sits in the execute stage, directly downstream of the ALU.

## Interface
- SHADOW_DEPTH, 2: number of shadow-stack entries (1-4); used only with CCR_SHADOW_EN.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- Stall  in  1  freezes all state; all inputs ignored.
- Alu_Flags  in  4  {V,C,N,Z} from ALU for the current instruction.
- Flag_WE  in  4  per-flag write mask, same bit order as Alu_Flags.
- Br_Req  in  1  conditional-branch evaluation request.
- Br_Cond  in  2  00=Z, 01=N, 10=C, 11=V.
- Int_Save  in  1  push CCR onto the shadow stack.
- Int_Restore  in  1  pop the shadow stack into CCR.
- CCR  out  4  stored flags {V,C,N,Z}.
- Carry_In  out  1  CCR[2]; combinational; drives ALU RLC/RRC.
- Br_Taken  out  1  registered branch decision.
- Shadow_Err  out  1  sticky push-overflow / pop-underflow error.

## Operation
- Flag update: at each edge, each flag with its Flag_WE bit = 1 loads its Alu_Flags bit; the other flags hold. SETC/CLRC arrive as Flag_WE=0100 with Alu_Flags[2] = 1 or 0.
- Branch: when Br_Req = 1, the flag selected by Br_Cond is read from the current CCR, before this edge's update.
  - If that flag is 1, Br_Taken = 1 on the next cycle and the flag is cleared at the same edge.
  - If Flag_WE also writes that flag in the same cycle, the ALU write wins over the clear.
  - Br_Taken = 0 in any cycle that follows no request.
- Shadow stack, LIFO of SHADOW_DEPTH entries with a count register:
  - Int_Save pushes the current CCR. Flag_WE updates in the same cycle still apply to CCR.
  - Int_Restore loads CCR from the top entry and pops it. Restore overrides both Flag_WE and the branch clear.
  - Push when full: the push is dropped and Shadow_Err is set.
  - Pop when empty: CCR holds and Shadow_Err is set.
  - Int_Save and Int_Restore together: no stack change, CCR follows the normal update rules, no error.
  - Shadow_Err clears only on reset.
- Stall = 1: CCR, stack, count, Br_Taken and Shadow_Err all hold their values.

## Timing
- Reset (asynchronous, active-high, also valid mid-operation): CCR=0000, Carry_In=0, Br_Taken=0, Shadow_Err=0, stack count=0. Stack entry contents are don't-care.
- Flag write latency: 1 cycle, so CCR reflects the write after the next rising edge.
- Branch latency: Br_Taken is valid exactly 1 cycle after Br_Req is sampled.
- Restore latency: 1 cycle. Back-to-back saves and restores are supported every cycle.
- Carry_In follows CCR[2] with no added latency.

## Configuration
- CCR_SHADOW_EN defined: the shadow stack and Shadow_Err are implemented as described above.
- CCR_SHADOW_EN undefined:
  - No stack storage is built.
  - Int_Save and Int_Restore are ignored.
  - Shadow_Err is tied to 0.
  - SHADOW_DEPTH is unused.
  - All other behaviour is unchanged.

## Test plan
- Reset check: assert RST mid-run with CCR=1111 -> CCR=0000, Br_Taken=0, Shadow_Err=0 immediately, without waiting for a clock edge.
- Masked write: Alu_Flags=1111, Flag_WE=0101 from CCR=0000 -> CCR=0101 next cycle. Then Flag_WE=0100, Alu_Flags=0000 (CLRC) -> CCR=0001, Carry_In=0.
- Branch taken and clear: CCR=0001, Br_Req=1, Br_Cond=00 -> Br_Taken=1, CCR=0000 next cycle. Repeat with Br_Cond=00 -> Br_Taken=0.
- Write beats clear: CCR=0100, Br_Req=1, Br_Cond=10, Flag_WE=0100, Alu_Flags=0100 -> Br_Taken=1, CCR=0100.
- Shadow nesting (CCR_SHADOW_EN, depth 2): save 0011, save 1100, save 0001 -> Shadow_Err=1. Then restore -> CCR=1100, restore -> CCR=0011, restore -> CCR holds 0011.
- Stall: Stall=1 with Flag_WE=1111, Br_Req=1, Int_Save=1 -> no change to any output or to the stack count.

Source files
------------

// File: rtl/ccr_unit.sv
// Condition-code register: ALU flag capture, branch evaluation with flag clear,
// and an optional interrupt shadow stack enabled by defining CCR_SHADOW_EN.
module ccr_unit #(
  parameter int SHADOW_DEPTH = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Stall,
  input  logic [3:0] Alu_Flags,
  input  logic [3:0] Flag_WE,
  input  logic       Br_Req,
  input  logic [1:0] Br_Cond,
  input  logic       Int_Save,
  input  logic       Int_Restore,
  output logic [3:0] CCR,
  output logic       Carry_In,
  output logic       Br_Taken,
  output logic       Shadow_Err
);

  logic [3:0] ccr_p1;
  logic       br_taken_p1;
  logic       br_hit;
  logic [3:0] ccr_upd;
  logic [3:0] ccr_nxt;

  // Branch clear is applied first so a same-cycle ALU write to that flag wins.
  always_comb begin
    br_hit  = Br_Req & ccr_p1[Br_Cond];
    ccr_upd = ccr_p1;
    if (br_hit) ccr_upd[Br_Cond] = 1'b0;
    ccr_upd = (ccr_upd & ~Flag_WE) | (Alu_Flags & Flag_WE);
  end

`ifdef CCR_SHADOW_EN
  localparam int CNT_W = $clog2(SHADOW_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(SHADOW_DEPTH);

  logic [CNT_W-1:0] cnt_p1;
  logic             err_p1;
  logic [3:0]       stack_p1 [SHADOW_DEPTH];
  logic [3:0]       top;
  logic             push;
  logic             pop;

  // Simultaneous save and restore cancel each other out.
  assign push = Int_Save & ~Int_Restore;
  assign pop  = Int_Restore & ~Int_Save;

  always_comb begin
    top = '0;
    for (int i = 0; i < SHADOW_DEPTH; i++)
      if (cnt_p1 == CNT_W'(i + 1)) top = stack_p1[i];
  end

  always_comb begin
    ccr_nxt = ccr_upd;
    if (pop) ccr_nxt = (cnt_p1 != '0) ? top : ccr_p1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_p1 <= '0;
      err_p1 <= 1'b0;
    end else if (!Stall) begin
      if (push) begin
        if (cnt_p1 == DEPTH_C) err_p1 <= 1'b1;
        else                   cnt_p1 <= cnt_p1 + 1'b1;
      end
      if (pop) begin
        if (cnt_p1 == '0) err_p1 <= 1'b1;
        else              cnt_p1 <= cnt_p1 - 1'b1;
      end
    end
  end

  // Stack entries carry no reset; the count alone defines which are live.
  always_ff @(posedge CLK) begin
    if (!Stall && push && (cnt_p1 != DEPTH_C)) begin
      for (int i = 0; i < SHADOW_DEPTH; i++)
        if (cnt_p1 == CNT_W'(i)) stack_p1[i] <= ccr_p1;
    end
  end

  assign Shadow_Err = err_p1;
`else
  localparam int unused_depth = SHADOW_DEPTH;
  logic unused_int;

  assign unused_int = Int_Save ^ Int_Restore;
  assign ccr_nxt    = ccr_upd;
  assign Shadow_Err = 1'b0;
`endif

  // Execute-stage register boundary
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ccr_p1      <= '0;
      br_taken_p1 <= 1'b0;
    end else if (!Stall) begin
      ccr_p1      <= ccr_nxt;
      br_taken_p1 <= br_hit;
    end
  end

  assign CCR      = ccr_p1;
  assign Carry_In = ccr_p1[2];
  assign Br_Taken = br_taken_p1;

endmodule

// File: tb/tb_ccr_unit.sv
// Self-checking bench for ccr_unit: directed literal checks plus randomized
// stimulus against a queue-based flag model compared on every falling edge.
module tb_ccr_unit;

  localparam int DEPTH = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Stall;
  logic [3:0] Alu_Flags;
  logic [3:0] Flag_WE;
  logic       Br_Req;
  logic [1:0] Br_Cond;
  logic       Int_Save;
  logic       Int_Restore;
  logic [3:0] CCR;
  logic       Carry_In;
  logic       Br_Taken;
  logic       Shadow_Err;

  ccr_unit #(.SHADOW_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .Stall(Stall), .Alu_Flags(Alu_Flags),
    .Flag_WE(Flag_WE), .Br_Req(Br_Req), .Br_Cond(Br_Cond),
    .Int_Save(Int_Save), .Int_Restore(Int_Restore), .CCR(CCR),
    .Carry_In(Carry_In), .Br_Taken(Br_Taken), .Shadow_Err(Shadow_Err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [3:0] m_ccr;
  logic       m_bt;
  logic       m_err;
  logic [3:0] m_stack[$];
  bit         chk_on = 1'b0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ccr = 4'b0000;
    m_bt  = 1'b0;
    m_err = 1'b0;
    m_stack.delete();
  endtask

  // Applies one clock edge's worth of rules to the model, using held inputs.
  task automatic model_edge();
    logic [3:0] n;
    logic       sel;
    if (Stall) return;
    sel  = m_ccr[Br_Cond];
    n    = m_ccr;
    if (Br_Req && sel) n[Br_Cond] = 1'b0;
    for (int b = 0; b < 4; b++)
      if (Flag_WE[b]) n[b] = Alu_Flags[b];
`ifdef CCR_SHADOW_EN
    if (Int_Save && !Int_Restore) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(m_ccr);
      else m_err = 1'b1;
    end
    if (Int_Restore && !Int_Save) begin
      if (m_stack.size() > 0) n = m_stack.pop_back();
      else begin
        n     = m_ccr;
        m_err = 1'b1;
      end
    end
`endif
    m_bt  = Br_Req && sel;
    m_ccr = n;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    Stall = 0; Alu_Flags = 0; Flag_WE = 0; Br_Req = 0; Br_Cond = 0;
    Int_Save = 0; Int_Restore = 0;
  endtask

  // Asynchronous reset pulse, checked before any clock edge arrives.
  task automatic do_reset(input string tag);
    #1 RST = 1'b1;
    #1;
    model_reset();
    cmp({tag, "_ccr"}, CCR, 0);
    cmp({tag, "_bt"}, Br_Taken, 0);
    cmp({tag, "_err"}, Shadow_Err, 0);
    cmp({tag, "_cin"}, Carry_In, 0);
    @(negedge CLK);
    #1 RST = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      cmp("m_ccr", CCR, m_ccr);
      cmp("m_cin", Carry_In, m_ccr[2]);
      cmp("m_bt", Br_Taken, m_bt);
      cmp("m_err", Shadow_Err, m_err);
    end
  end

  initial begin
    idle_in();
    RST = 1'b1;
    model_reset();
    #12;
    cmp("rst_ccr", CCR, 0);
    cmp("rst_bt", Br_Taken, 0);
    cmp("rst_err", Shadow_Err, 0);
    RST = 1'b0;
    chk_on = 1'b1;

    // Masked write then CLRC
    Alu_Flags = 4'b1111; Flag_WE = 4'b0101;
    step();
    cmp("mask_wr", CCR, 4'b0101);
    Alu_Flags = 4'b0000; Flag_WE = 4'b0100;
    step();
    cmp("clrc_ccr", CCR, 4'b0001);
    cmp("clrc_cin", Carry_In, 0);

    // Branch taken clears Z; repeat is not taken
    idle_in(); Br_Req = 1; Br_Cond = 2'b00;
    step();
    cmp("br1_taken", Br_Taken, 1);
    cmp("br1_ccr", CCR, 4'b0000);
    step();
    cmp("br2_taken", Br_Taken, 0);
    idle_in();
    step();
    cmp("br_idle", Br_Taken, 0);

    // ALU write beats branch clear
    Alu_Flags = 4'b0100; Flag_WE = 4'b1111;
    step();
    Br_Req = 1; Br_Cond = 2'b10; Flag_WE = 4'b0100; Alu_Flags = 4'b0100;
    step();
    cmp("wbc_taken", Br_Taken, 1);
    cmp("wbc_ccr", CCR, 4'b0100);
    cmp("wbc_cin", Carry_In, 1);

    // Stall freezes everything
    Stall = 1; Flag_WE = 4'b1111; Alu_Flags = 4'b1011; Br_Req = 1;
    Br_Cond = 2'b10; Int_Save = 1;
    step();
    step();
    cmp("stall_ccr", CCR, 4'b0100);
    cmp("stall_bt", Br_Taken, 1);
    cmp("stall_err", Shadow_Err, 0);
`ifdef CCR_SHADOW_EN
    // Stack must still be empty after the stalled save
    idle_in(); Int_Restore = 1;
    step();
    cmp("stall_cnt_ccr", CCR, 4'b0100);
    cmp("stall_cnt_err", Shadow_Err, 1);
    idle_in();
    do_reset("rst2");

    // Shadow nesting, depth 2
    Flag_WE = 4'b1111; Alu_Flags = 4'b0011;
    step();
    Int_Save = 1; Alu_Flags = 4'b1100;
    step();
    Alu_Flags = 4'b0001;
    step();
    cmp("sh_err0", Shadow_Err, 0);
    Flag_WE = 4'b0000;
    step();
    cmp("sh_ovf", Shadow_Err, 1);
    cmp("sh_ccr_ovf", CCR, 4'b0001);
    idle_in(); Int_Restore = 1;
    step();
    cmp("sh_pop1", CCR, 4'b1100);
    step();
    cmp("sh_pop2", CCR, 4'b0011);
    step();
    cmp("sh_pop3", CCR, 4'b0011);
    cmp("sh_unf_err", Shadow_Err, 1);
    // Save and restore together: plain update, no stack change
    Int_Save = 1; Flag_WE = 4'b1000; Alu_Flags = 4'b1000;
    step();
    cmp("sh_both", CCR, 4'b1011);
`endif
    idle_in();

    // Mid-run reset with all flags set
    Flag_WE = 4'b1111; Alu_Flags = 4'b1111;
    step();
    cmp("pre_rst", CCR, 4'b1111);
    idle_in();
    do_reset("rst3");

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle_in();
        do_reset("rrst");
      end
      Stall       = ($urandom_range(0, 9) == 0);
      Alu_Flags   = 4'($urandom);
      Flag_WE     = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      Br_Req      = 1'($urandom);
      Br_Cond     = 2'($urandom);
      Int_Save    = ($urandom_range(0, 3) == 0);
      Int_Restore = ($urandom_range(0, 3) == 0);
      step();
    end

    idle_in();
    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
